trigger_ctrl: RTL and testbench

//  Conditions the external push-button trigger before it reaches the pipelined CPU top.

---
 rtl/trigger_pkg.sv | 25 ++
 rtl/trigger_ctrl_if.sv | 43 ++++
 rtl/trigger_ctrl_sync_ff.sv | 32 +++
 rtl/trigger_ctrl.sv | 145 ++++++++++++++
 tb/tb_trigger_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/trigger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_pkg
//  Description : Shared types and helpers for the push-button trigger
//                conditioner.
//                trig_state_t - debounce FSM state encoding
//                cnt_width()  - counter width for a given modulus (min 1 bit)
//  Revision    : 1.0 - initial release
// ============================================================================
package trigger_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } trig_state_t;

    // Bits needed to count 0..n-1; never returns less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : trigger_pkg
`default_nettype wire

// File: rtl/trigger_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_ctrl_if
//  Description : Trigger conditioner signal bundle.
//                trigger_raw  - raw asynchronous button level
//                ack          - one-cycle acknowledge from the core
//                trig_pulse   - one-cycle strobe per accepted press/repeat
//                trig_pending - sticky request level towards the core
//                trig_level   - debounced button level
//                press_count  - wrapping count of strobes (CNT_W bits)
//                Modport master: the conditioner. Modport slave: the consumer
//                (button source and core side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface trigger_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             trigger_raw;
    logic             ack;
    logic             trig_pulse;
    logic             trig_pending;
    logic             trig_level;
    logic [CNT_W-1:0] press_count;

    modport master (
        input  trigger_raw,
        input  ack,
        output trig_pulse,
        output trig_pending,
        output trig_level,
        output press_count
    );

    modport slave (
        output trigger_raw,
        output ack,
        input  trig_pulse,
        input  trig_pending,
        input  trig_level,
        input  press_count
    );
endinterface : trigger_ctrl_if
`default_nettype wire

// File: rtl/trigger_ctrl_sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : STAGES-flop synchroniser for a single asynchronous bit,
//                synchronous active-high reset to 0.
//                clk   - destination clock
//                reset - synchronous active-high reset
//                d     - asynchronous input
//                q     - synchronised output (d delayed by STAGES edges)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic d,
    output logic      q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];
endmodule : sync_ff
`default_nettype wire

// File: rtl/trigger_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trigger_ctrl
//  Description : Push-button trigger conditioner. Synchronises, debounces
//                and edge-detects the raw button, emits a one-cycle strobe
//                per accepted press and holds a sticky pending request until
//                the core acknowledges it.
//                clk   - system clock, rising edge
//                reset - synchronous active-high reset
//                bus   - trigger_ctrl_if.master (raw/ack in; pulse, pending,
//                        level and press count out)
//                Optional feature macro: TRIGGER_AUTOREPEAT_EN - while the
//                button stays pressed, an extra strobe fires every
//                REPEAT_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module trigger_ctrl
    import trigger_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 8,
    parameter int REPEAT_CYCLES   = 50000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    trigger_ctrl_if.master  bus
);
    localparam int              DEB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_err
        $error("trigger_ctrl: SYNC_STAGES, DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic             w_sync_q;
    logic             w_fire;
    trig_state_t      r_state;
    logic [DEB_W-1:0] r_deb_cnt;
    logic             r_pulse;
    logic             r_pending;
    logic             r_level;
    logic [CNT_W-1:0] r_count;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.trigger_raw),
        .q     (w_sync_q)
    );

`ifdef TRIGGER_AUTOREPEAT_EN
    localparam int              RPT_W    = cnt_width(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] r_rpt_cnt;
    logic             w_repeat;

    // Repeat only while the button is still seen held in PRESSED.
    assign w_repeat = (r_state == PRESSED) && w_sync_q && (r_rpt_cnt == RPT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rpt_cnt <= '0;
        end else if (r_state == DEB_PRESS) begin
            r_rpt_cnt <= '0;
        end else if (r_state == PRESSED && w_sync_q) begin
            r_rpt_cnt <= w_repeat ? '0 : r_rpt_cnt + 1'b1;
        end
        // DEB_RELEASE and IDLE hold the repeat phase.
    end
`else
    logic w_repeat;
    assign w_repeat = 1'b0;
`endif

    // Accepted press: the final stable cycle of the press debounce.
    assign w_fire = ((r_state == DEB_PRESS) && w_sync_q && (r_deb_cnt == DEB_LAST))
                  || w_repeat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_deb_cnt <= '0;
            r_pulse   <= 1'b0;
            r_pending <= 1'b0;
            r_level   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_pulse <= w_fire;
            if (w_fire) begin
                r_count <= r_count + 1'b1;
            end
            // Set wins over ack so a press coinciding with ack is not lost.
            r_pending <= w_fire | (r_pending & ~bus.ack);

            case (r_state)
                IDLE: begin
                    if (w_sync_q) begin
                        r_state   <= DEB_PRESS;
                        r_deb_cnt <= '0;
                    end
                end
                DEB_PRESS: begin
                    if (!w_sync_q) begin
                        r_state   <= IDLE;
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_state <= PRESSED;
                        r_level <= 1'b1;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_sync_q) begin
                        r_state   <= DEB_RELEASE;
                        r_deb_cnt <= '0;
                    end
                end
                DEB_RELEASE: begin
                    if (w_sync_q) begin
                        r_state <= PRESSED;
                    end else if (r_deb_cnt == DEB_LAST) begin
                        r_state <= IDLE;
                        r_level <= 1'b0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trig_pulse   = r_pulse;
    assign bus.trig_pending = r_pending;
    assign bus.trig_level   = r_level;
    assign bus.press_count  = r_count;
endmodule : trigger_ctrl
`default_nettype wire

// File: tb/tb_trigger_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trigger_ctrl
//  Description : Directed self-checking bench for trigger_ctrl with
//                SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=8, REPEAT_CYCLES=10.
//                Honors TRIGGER_AUTOREPEAT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_ctrl;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_W           = 8;
    localparam int REPEAT_CYCLES   = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulses;

    always #5 clk = ~clk;

    trigger_ctrl_if #(.CNT_W(CNT_W)) bus ();

    trigger_ctrl #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pulse"},   32'(bus.trig_pulse),   32'd0);
        check_eq({tag, "_pending"}, 32'(bus.trig_pending), 32'd0);
        check_eq({tag, "_level"},   32'(bus.trig_level),   32'd0);
        check_eq({tag, "_count"},   32'(bus.press_count),  32'd0);
    endtask

    task automatic press_release();
        bus.trigger_raw = 1'b1;
        repeat (10) tick();
        bus.trigger_raw = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        int bounce [5];
        bounce = '{1, 1, 0, 1, 0};

        reset           = 1'b1;
        bus.trigger_raw = 1'b0;
        bus.ack         = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // 1: clean press, strobe after edge 7
        bus.trigger_raw = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check_eq("t1_no_early_pulse", 32'(bus.trig_pulse), 32'd0);
        end
        tick();
        check_eq("t1_pulse",   32'(bus.trig_pulse),   32'd1);
        check_eq("t1_count",   32'(bus.press_count),  32'd1);
        check_eq("t1_pending", 32'(bus.trig_pending), 32'd1);
        check_eq("t1_level",   32'(bus.trig_level),   32'd1);
        tick();
        check_eq("t1_pulse_one_cycle", 32'(bus.trig_pulse), 32'd0);
        bus.trigger_raw = 1'b0;
        repeat (10) tick();
        check_eq("t1_level_released", 32'(bus.trig_level),   32'd0);
        check_eq("t1_pending_sticky", 32'(bus.trig_pending), 32'd1);

        // 2: bounce shorter than the debounce window
        pulses = 0;
        foreach (bounce[i]) begin
            bus.trigger_raw = bounce[i][0];
            tick();
            pulses += int'(bus.trig_pulse);
        end
        repeat (8) begin
            tick();
            pulses += int'(bus.trig_pulse);
        end
        check_eq("t2_no_strobe", 32'(pulses),          32'd0);
        check_eq("t2_count",     32'(bus.press_count), 32'd1);
        check_eq("t2_level",     32'(bus.trig_level),  32'd0);

        // 3b: ack coincident with a new strobe keeps pending set
        bus.trigger_raw = 1'b1;
        repeat (6) tick();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check_eq("t3_coinc_pulse",   32'(bus.trig_pulse),   32'd1);
        check_eq("t3_coinc_pending", 32'(bus.trig_pending), 32'd1);
        check_eq("t3_coinc_count",   32'(bus.press_count),  32'd2);
        tick();
        check_eq("t3_coinc_pending_after", 32'(bus.trig_pending), 32'd1);
        bus.trigger_raw = 1'b0;
        repeat (10) tick();

        // 3a: plain ack clears pending; ack while idle is ignored
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check_eq("t3_ack_clears", 32'(bus.trig_pending), 32'd0);
        tick();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check_eq("t3_ack_idle", 32'(bus.trig_pending), 32'd0);
        check_eq("t3_count",    32'(bus.press_count),  32'd2);

        // 4: press_count wraps FF -> 00
        repeat (253) press_release();
        check_eq("t4_count_ff", 32'(bus.press_count),  32'hFF);
        check_eq("t4_pending",  32'(bus.trig_pending), 32'd1);
        bus.trigger_raw = 1'b1;
        repeat (7) tick();
        check_eq("t4_wrap_pulse", 32'(bus.trig_pulse),  32'd1);
        check_eq("t4_wrap_count", 32'(bus.press_count), 32'h00);
        bus.trigger_raw = 1'b0;
        repeat (10) tick();

        // 5: reset during DEB_PRESS with deb_cnt=2, button held throughout
        bus.trigger_raw = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("t5_reset");
        for (int e = 1; e <= 6; e++) begin
            tick();
            check_eq("t5_no_early_pulse", 32'(bus.trig_pulse), 32'd0);
        end
        tick();
        check_eq("t5_pulse", 32'(bus.trig_pulse),  32'd1);
        check_eq("t5_count", 32'(bus.press_count), 32'd1);

        // 6: keep holding for 40 cycles after the first strobe
        pulses = 0;
        repeat (40) begin
            tick();
            pulses += int'(bus.trig_pulse);
        end
`ifdef TRIGGER_AUTOREPEAT_EN
        check_eq("t6_repeats", 32'(pulses),          32'd4);
        check_eq("t6_count",   32'(bus.press_count), 32'd5);
`else
        check_eq("t6_repeats", 32'(pulses),          32'd0);
        check_eq("t6_count",   32'(bus.press_count), 32'd1);
`endif
        check_eq("t6_level", 32'(bus.trig_level), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_trigger_ctrl
`default_nettype wire
